// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the boot-time program loader.
//
// Contents:
//   loader_state_t  - FSM state enum, ST_IDLE .. ST_DONE
//   LOADER_*        - default data, address and run-counter widths
package loader_pkg;

   localparam int unsigned LOADER_WIDTH     = 8;
   localparam int unsigned LOADER_A_WIDTH   = 5;
   localparam int unsigned LOADER_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } loader_state_t;

   // States in which a start request is honoured.
   function automatic logic accepts_start(loader_state_t st);
      return (st == ST_IDLE) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
//
// Signals:
//   s_valid/s_data/s_last  stream byte, valid and end-of-program marker
//   s_ready                loader accepts a byte this cycle
//   mem_sel                loader owns the memory bus
//   mem_wr/mem_addr/mem_wdata  memory write port
// Modports:
//   master - byte source / memory side (drives stream, observes memory bus)
//   slave  - the loader (consumes stream, drives memory bus)
interface prog_loader_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned A_WIDTH = 5
) ();

   logic               s_valid;
   logic [WIDTH-1:0]   s_data;
   logic               s_last;
   logic               s_ready;
   logic               mem_sel;
   logic               mem_wr;
   logic [A_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]   mem_wdata;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, mem_sel, mem_wr, mem_addr, mem_wdata
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, mem_sel, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/prog_loader_counter.sv
// counter_gen: generic up-counter with synchronous load-to-zero.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (count to 0)
//   load_i    clear count to 0 (priority over enable_i)
//   enable_i  increment by one, wrapping at all-ones
//   count_o   current count
module counter_gen #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             enable_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: holds the accumulator CPU in reset, streams a program into its
// 2^A_WIDTH x WIDTH memory from address 0, releases the CPU and counts run
// cycles until halt.
//
// Build option: define LOADER_CLEAR_EN to zero-fill memory above the program
// (CLEAR state) before the CPU runs; undefined, LOAD goes straight to RUN.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   start_i     begin a load (honoured in IDLE and DONE only)
//   bus_io      stream input and memory write bus (slave modport)
//   cpu_halt_i  CPU halt
//   cpu_rst_o   CPU reset, low only in RUN
//   busy_o      high in LOAD, CLEAR and RUN
//   done_o      high in DONE
//   cycles_o    run-cycle count (saturating), valid in DONE
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned WIDTH     = LOADER_WIDTH,
   parameter int unsigned A_WIDTH   = LOADER_A_WIDTH,
   parameter int unsigned CNT_WIDTH = LOADER_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   prog_loader_if.slave         bus_io,
   input  logic                 cpu_halt_i,
   output logic                 cpu_rst_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] cycles_o
);

   localparam logic [A_WIDTH-1:0]   ADDR_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CYCLE_MAX = '1;

   loader_state_t        state_d, state_q;
   logic [CNT_WIDTH-1:0] cycles_d, cycles_q;
   logic [A_WIDTH-1:0]   addr;
   logic                 addr_load, addr_en, at_max;

   logic                 s_ready;
   logic                 mem_sel;
   logic                 mem_wr;
   logic [A_WIDTH-1:0]   mem_addr;
   logic [WIDTH-1:0]     mem_wdata;

   counter_gen #(
      .WIDTH (A_WIDTH)
   ) u_addr_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (addr_load),
      .enable_i (addr_en),
      .count_o  (addr)
   );

   assign at_max = (addr == ADDR_MAX);

   always_comb begin
      state_d   = state_q;
      cycles_d  = cycles_q;
      addr_load = 1'b0;
      addr_en   = 1'b0;
      s_ready   = 1'b0;
      mem_sel   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rst_o = 1'b1;
      busy_o    = 1'b0;
      done_o    = 1'b0;

      if (accepts_start(state_q) && start_i) begin
         state_d   = ST_LOAD;
         cycles_d  = '0;
         addr_load = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: ;
         ST_LOAD: begin
            s_ready  = 1'b1;
            mem_sel  = 1'b1;
            busy_o   = 1'b1;
            mem_addr = addr;
            if (bus_io.s_valid) begin
               mem_wr    = 1'b1;
               mem_wdata = bus_io.s_data;
               // Hold at the top address so a forced-last byte never wraps.
               addr_en   = !at_max;
               if (bus_io.s_last || at_max) begin
`ifdef LOADER_CLEAR_EN
                  state_d = at_max ? ST_RUN : ST_CLEAR;
`else
                  state_d = ST_RUN;
`endif
               end
            end
         end
`ifdef LOADER_CLEAR_EN
         ST_CLEAR: begin
            // Counter already points at final+1 when this state is entered.
            mem_sel  = 1'b1;
            mem_wr   = 1'b1;
            busy_o   = 1'b1;
            mem_addr = addr;
            addr_en  = !at_max;
            if (at_max) begin
               state_d = ST_RUN;
            end
         end
`endif
         ST_RUN: begin
            cpu_rst_o = 1'b0;
            busy_o    = 1'b1;
            if (cpu_halt_i) begin
               state_d = ST_DONE;
            end else if (cycles_q != CYCLE_MAX) begin
               cycles_d = cycles_q + CNT_WIDTH'(1);
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         cycles_q <= cycles_d;
      end
   end

   assign bus_io.s_ready   = s_ready;
   assign bus_io.mem_sel   = mem_sel;
   assign bus_io.mem_wr    = mem_wr;
   assign bus_io.mem_addr  = mem_addr;
   assign bus_io.mem_wdata = mem_wdata;
   assign cycles_o         = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader. A reference memory image and
// expected handshake behaviour are derived from the loading rules; the DUT's
// writes land in a modelled CPU memory that is compared against the image.
// Build option LOADER_CLEAR_EN is honoured the same way as in the design.
module tb_prog_loader;

   localparam int unsigned TB_CW = 6;          // small so saturation is reachable
   localparam int unsigned CMAX  = (1 << TB_CW) - 1;
   localparam int unsigned DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             cpu_halt = 1'b0;
   logic             cpu_rst, busy, done;
   logic [TB_CW-1:0] cycles;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] dut_mem [DEPTH] = '{default: 8'h00};
   logic [7:0] exp_mem [DEPTH] = '{default: 8'h00};

   prog_loader_if #(.WIDTH(8), .A_WIDTH(5)) bus ();

   prog_loader #(
      .WIDTH     (8),
      .A_WIDTH   (5),
      .CNT_WIDTH (TB_CW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .bus_io     (bus),
      .cpu_halt_i (cpu_halt),
      .cpu_rst_o  (cpu_rst),
      .busy_o     (busy),
      .done_o     (done),
      .cycles_o   (cycles)
   );

   always #5 clk = ~clk;

   // CPU memory as seen through the loader's write port.
   always @(posedge clk) begin
      if (bus.mem_sel && bus.mem_wr) dut_mem[bus.mem_addr] <= bus.mem_wdata;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem();
      for (int i = 0; i < DEPTH; i++) begin
         check_eq($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(exp_mem[i]));
      end
   endtask

   // Load n random bytes; s_last on the last one if use_last. Leaves the DUT
   // one cycle into RUN (that cycle had halt low, so it counts once).
   task automatic do_load(input int n, input bit use_last, input int gap_pct);
      logic [7:0] prog [DEPTH];
      int idx, budget;
      bit v;
      for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      idx = 0;
      budget = 0;
      while (idx < n && budget < 400) begin
         v = ($urandom_range(99) >= gap_pct);
         bus.s_valid = v;
         bus.s_data  = prog[idx];
         bus.s_last  = use_last && (idx == n - 1);
         @(negedge clk);
         if (budget == 0) check_eq("ld_cycles_clr", 32'(cycles), 0);
         check_eq("ld_ready", 32'(bus.s_ready), 1);
         check_eq("ld_sel", 32'(bus.mem_sel), 1);
         check_eq("ld_cpu_rst", 32'(cpu_rst), 1);
         check_eq("ld_wr", 32'(bus.mem_wr), 32'(v));
         if (v) begin
            check_eq("ld_addr", 32'(bus.mem_addr), 32'(idx));
            check_eq("ld_wdata", 32'(bus.mem_wdata), 32'(prog[idx]));
         end
         next_cycle();
         if (v) idx++;
         budget++;
      end
      if (idx < n) check_eq("ld_budget", 32'(idx), 32'(n));
      for (int i = 0; i < n; i++) exp_mem[i] = prog[i];
      // Stray stream traffic after the final byte must be ignored.
      bus.s_valid = 1'($urandom_range(1));
      bus.s_data  = 8'hEE;
      bus.s_last  = 1'b0;
`ifdef LOADER_CLEAR_EN
      for (int k = n; k < DEPTH; k++) begin
         @(negedge clk);
         check_eq("clr_wr", 32'(bus.mem_wr), 1);
         check_eq("clr_addr", 32'(bus.mem_addr), 32'(k));
         check_eq("clr_wdata", 32'(bus.mem_wdata), 0);
         check_eq("clr_ready", 32'(bus.s_ready), 0);
         check_eq("clr_cpu_rst", 32'(cpu_rst), 1);
         exp_mem[k] = 8'h00;
         next_cycle();
      end
`endif
      @(negedge clk);
      check_eq("run_cpu_rst", 32'(cpu_rst), 0);
      check_eq("run_ready", 32'(bus.s_ready), 0);
      check_eq("run_wr", 32'(bus.mem_wr), 0);
      check_eq("run_sel", 32'(bus.mem_sel), 0);
      check_eq("run_busy", 32'(busy), 1);
      next_cycle();
      bus.s_valid = 1'b0;
      check_mem();
   endtask

   // Continue RUN so that r cycles in total have halt low, then halt.
   task automatic do_run(input int r);
      int exp_cyc;
      for (int i = 1; i < r; i++) begin
         start = (i == r / 2);           // ignored in RUN
         @(negedge clk);
         check_eq("run_hold", 32'(cpu_rst), 0);
         next_cycle();
         start = 1'b0;
      end
      cpu_halt = 1'b1;
      @(negedge clk);
      check_eq("halt_done_early", 32'(done), 0);
      next_cycle();
      cpu_halt = 1'b0;
      exp_cyc = (r > int'(CMAX)) ? int'(CMAX) : r;
      @(negedge clk);
      check_eq("done", 32'(done), 1);
      check_eq("done_cpu_rst", 32'(cpu_rst), 1);
      check_eq("done_busy", 32'(busy), 0);
      check_eq("done_cycles", 32'(cycles), 32'(exp_cyc));
      next_cycle();
      next_cycle();
      @(negedge clk);
      check_eq("done_cycles_hold", 32'(cycles), 32'(exp_cyc));
      next_cycle();
   endtask

   initial begin
      int n;
      bit ul;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.s_last  = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.s_ready), 0);
      check_eq("rst_sel", 32'(bus.mem_sel), 0);
      check_eq("rst_wr", 32'(bus.mem_wr), 0);
      check_eq("rst_addr", 32'(bus.mem_addr), 0);
      check_eq("rst_wdata", 32'(bus.mem_wdata), 0);
      check_eq("rst_cpu_rst", 32'(cpu_rst), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_cycles", 32'(cycles), 0);
      next_cycle();

      // Short program, gap-free, then a 10-cycle run; later start from DONE.
      do_load(3, 1'b1, 0);
      do_run(10);

      // Gappy stream exercising idle handshake cycles.
      do_load(5, 1'b1, 50);
      do_run(4);

      // Reset mid-load after three bytes.
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'($urandom);
         bus.s_last  = 1'b0;
         next_cycle();
      end
      bus.s_valid = 1'b0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_ready", 32'(bus.s_ready), 0);
      check_eq("mid_rst_cpu_rst", 32'(cpu_rst), 1);
      check_eq("mid_rst_cycles", 32'(cycles), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      next_cycle();
      // Abandoned load leaves memory undefined: adopt what the DUT wrote.
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = dut_mem[i];

      // Full-depth program without s_last (forced last), then with it.
      do_load(32, 1'b0, 20);
      do_run(2);
      do_load(32, 1'b1, 0);
      do_run(70);                        // saturates the counter

      for (int t = 0; t < 8; t++) begin
         n  = $urandom_range(1, 32);
         ul = (n < 32) ? 1'b1 : 1'($urandom_range(1));
         do_load(n, ul, $urandom_range(0, 60));
         do_run($urandom_range(1, 25));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
